// File: rtl/clk_ctrl_unit_pkg.sv
// Shared mode codes, FSM state encodings and reset divisor for the processor
// clock control unit.
package clk_ctrl_unit_pkg;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    localparam logic [1:0] ST_HALT      = 2'b00;
    localparam logic [1:0] ST_RUN       = 2'b01;
    localparam logic [1:0] ST_STEP_WAIT = 2'b10;
    localparam logic [1:0] ST_STEP_FIRE = 2'b11;

    localparam int DEFAULT_DIV_VAL = 104166;

    // State a mode request leads to once the current state may be left;
    // the reserved code 11 behaves as HALT.
    function automatic logic [1:0] mode_target(input logic [1:0] mode_val);
        logic [1:0] st;
        case (mode_val)
            MODE_RUN:  st = ST_RUN;
            MODE_STEP: st = ST_STEP_WAIT;
            default:   st = ST_HALT;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/clk_ctrl_unit_step_edge_sync.sv
// Synchronizer chain for the asynchronous step button plus a rising-edge
// detector producing a single-cycle pulse.
module clk_ctrl_unit_step_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic step_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   edge_q;

    assign sync_d[0] = step_i;

    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_chain
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse_o = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/clk_ctrl_unit.sv
// Processor clock sequencer: HALT / free-running RUN / single STEP, with a
// runtime-reloadable divisor and a tick aligned to every clk_out rise.
module clk_ctrl_unit
    import clk_ctrl_unit_pkg::*;
#(
    parameter int CNT_W       = 20,
    parameter int DEFAULT_DIV = DEFAULT_DIV_VAL,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             step_req,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_value,
    output logic             div_ack,
    output logic             div_err,
    output logic             clk_out,
    output logic             tick,
    output logic [1:0]       state
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pend_valid_q, pend_valid_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic             step_pulse;
    logic             wrap;
    logic             load_ok;
    logic [CNT_W-1:0] div_m1;

    clk_ctrl_unit_step_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_step_sync (
        .clk_in (clk_in),
        .reset  (reset),
        .step_i (step_req),
        .pulse_o(step_pulse)
    );

    assign div_m1  = div_q - CNT_W'(1);
    assign wrap    = (state_q == ST_RUN) && (cnt_q == div_m1);
    assign load_ok = div_load && (div_value >= CNT_W'(2));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        case (state_q)
            ST_HALT: begin
                clk_d = 1'b0;
                cnt_d = '0;
                if (mode == MODE_RUN || mode == MODE_STEP)
                    state_d = mode_target(mode);
            end
            ST_RUN: begin
                // Leave only on a falling edge (or when sitting at the start
                // of a low phase) so no shortened high pulse ever escapes.
                if (mode != MODE_RUN && !clk_q && cnt_q == '0) begin
                    state_d = mode_target(mode);
                end else if (wrap) begin
                    cnt_d  = '0;
                    clk_d  = ~clk_q;
                    tick_d = ~clk_q;
                    if (clk_q && mode != MODE_RUN)
                        state_d = mode_target(mode);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STEP_WAIT: begin
                clk_d = 1'b0;
                cnt_d = '0;
                if (mode != MODE_STEP) begin
                    state_d = mode_target(mode);
                end else if (step_pulse) begin
                    state_d = ST_STEP_FIRE;
                    clk_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            default: begin
                clk_d   = 1'b0;
                cnt_d   = '0;
                state_d = mode_target(mode);
            end
        endcase
    end

    // While running, a new divisor waits for the next wrap so the current
    // half-period is never cut short; a later load simply replaces it.
    always_comb begin
        div_d        = div_q;
        pend_val_d   = pend_val_q;
        pend_valid_d = pend_valid_q;
        ack_d        = 1'b0;
        err_d        = div_load && (div_value < CNT_W'(2));
        if (state_q == ST_RUN) begin
            if (wrap && (load_ok || pend_valid_q)) begin
                div_d        = load_ok ? div_value : pend_val_q;
                ack_d        = 1'b1;
                pend_valid_d = 1'b0;
            end else if (load_ok) begin
                pend_val_d   = div_value;
                pend_valid_d = 1'b1;
            end
        end else if (load_ok) begin
            div_d        = div_value;
            ack_d        = 1'b1;
            pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
            div_d        = pend_val_q;
            ack_d        = 1'b1;
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_HALT;
            cnt_q        <= '0;
            div_q        <= CNT_W'(DEFAULT_DIV);
            pend_val_q   <= '0;
            pend_valid_q <= 1'b0;
            clk_q        <= 1'b0;
            tick_q       <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            pend_val_q   <= pend_val_d;
            pend_valid_q <= pend_valid_d;
            clk_q        <= clk_d;
            tick_q       <= tick_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign div_ack = ack_q;
    assign div_err = err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_clk_ctrl_unit.sv
// Directed bench for clk_ctrl_unit: per-cycle expectations are queued as the
// stimulus is driven and popped/checked one clock later.
module tb_clk_ctrl_unit;

    localparam int CNT_W = 20;
    localparam logic [1:0] S_HALT = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_SW   = 2'b10;
    localparam logic [1:0] S_SF   = 2'b11;

    logic             clk_in = 1'b0;
    logic             reset;
    logic [1:0]       mode;
    logic             step_req;
    logic             div_load;
    logic [CNT_W-1:0] div_value;
    logic             div_ack;
    logic             div_err;
    logic             clk_out;
    logic             tick;
    logic [1:0]       state;

    typedef struct {
        string      tag;
        logic       co;
        logic       tk;
        logic [1:0] st;
        logic       ack;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    clk_ctrl_unit #(
        .CNT_W(CNT_W),
        .DEFAULT_DIV(4),
        .SYNC_STAGES(2)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .mode     (mode),
        .step_req (step_req),
        .div_load (div_load),
        .div_value(div_value),
        .div_ack  (div_ack),
        .div_err  (div_err),
        .clk_out  (clk_out),
        .tick     (tick),
        .state    (state)
    );

    always #5 clk_in = ~clk_in;

    task automatic push(input string tag, input logic co, input logic tk,
                        input logic [1:0] st, input logic ack = 1'b0,
                        input logic err = 1'b0);
        exp_t e;
        e.tag = tag; e.co = co; e.tk = tk; e.st = st; e.ack = ack; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic push_n(input string tag, input int n, input logic co,
                          input logic tk, input logic [1:0] st);
        for (int i = 0; i < n; i++) push(tag, co, tk, st);
    endtask

    // One full clk_out period starting at a rise, half-period h.
    task automatic push_period(input string tag, input int h);
        push(tag, 1'b1, 1'b1, S_RUN);
        push_n(tag, h - 1, 1'b1, 1'b0, S_RUN);
        push_n(tag, h, 1'b0, 1'b0, S_RUN);
    endtask

    task automatic compare(input exp_t e);
        checks += 5;
        assert (clk_out === e.co) else begin
            failures++;
            $error("FAIL %s clk_out got=%b exp=%b", e.tag, clk_out, e.co);
        end
        assert (tick === e.tk) else begin
            failures++;
            $error("FAIL %s tick got=%b exp=%b", e.tag, tick, e.tk);
        end
        assert (state === e.st) else begin
            failures++;
            $error("FAIL %s state got=%b exp=%b", e.tag, state, e.st);
        end
        assert (div_ack === e.ack) else begin
            failures++;
            $error("FAIL %s div_ack got=%b exp=%b", e.tag, div_ack, e.ack);
        end
        assert (div_err === e.err) else begin
            failures++;
            $error("FAIL %s div_err got=%b exp=%b", e.tag, div_err, e.err);
        end
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            @(posedge clk_in);
            #1;
            compare(exp_q.pop_front());
        end
    endtask

    task automatic check_now();
        compare(exp_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; mode = 2'b00; step_req = 1'b0;
        div_load = 1'b0; div_value = '0;

        // Reset state
        push_n("reset", 2, 1'b0, 1'b0, S_HALT);
        drain();
        @(posedge clk_in); #1;
        reset = 1'b1;
        push("halt_idle", 1'b0, 1'b0, S_HALT);
        drain();

        // 1: RUN with div 4 -> period 8, high 4 / low 4
        mode = 2'b01;
        push_n("run_start", 4, 1'b0, 1'b0, S_RUN);
        push_period("run_p8", 4);
        push_period("run_p8", 4);
        drain();

        // 3: HALT request one cycle into the high phase completes the phase
        push("run_rise", 1'b1, 1'b1, S_RUN);
        drain();
        mode = 2'b00;
        push_n("halt_finish_high", 3, 1'b1, 1'b0, S_RUN);
        push("halt_fall", 1'b0, 1'b0, S_HALT);
        push_n("halt_hold", 2, 1'b0, 1'b0, S_HALT);
        drain();

        // 2: one step pulse per rising edge, 3 cycles latency
        mode = 2'b10;
        push_n("step_wait", 2, 1'b0, 1'b0, S_SW);
        drain();
        step_req = 1'b1;
        push_n("step_sync", 2, 1'b0, 1'b0, S_SW);
        push("step_fire", 1'b1, 1'b1, S_SF);
        push_n("step_held", 17, 1'b0, 1'b0, S_SW);
        drain();
        step_req = 1'b0;
        push_n("step_low", 4, 1'b0, 1'b0, S_SW);
        drain();
        step_req = 1'b1;
        push_n("step2_sync", 2, 1'b0, 1'b0, S_SW);
        push("step2_fire", 1'b1, 1'b1, S_SF);
        push_n("step2_after", 3, 1'b0, 1'b0, S_SW);
        drain();

        // 6: step edge and mode change together -> mode wins, RUN from counter 0
        step_req = 1'b0;
        push_n("step_clear", 4, 1'b0, 1'b0, S_SW);
        drain();
        step_req = 1'b1;
        push_n("race_sync", 2, 1'b0, 1'b0, S_SW);
        drain();
        mode = 2'b01;
        push_n("race_run", 4, 1'b0, 1'b0, S_RUN);
        push_period("race_p8", 4);
        drain();

        // 4: divisor 6 loaded mid-period, applied on the next wrap
        push("ld_rise", 1'b1, 1'b1, S_RUN);
        push("ld_high", 1'b1, 1'b0, S_RUN);
        drain();
        div_load = 1'b1; div_value = 20'd6;
        push("ld_pending", 1'b1, 1'b0, S_RUN);
        drain();
        div_load = 1'b0;
        push("ld_pending", 1'b1, 1'b0, S_RUN);
        push("ld_ack", 1'b0, 1'b0, S_RUN, 1'b1, 1'b0);
        push_n("ld_low6", 5, 1'b0, 1'b0, S_RUN);
        push_period("ld_p12", 6);
        drain();
        div_load = 1'b1; div_value = 20'd1;
        push("ld_err", 1'b1, 1'b1, S_RUN, 1'b0, 1'b1);
        drain();
        div_load = 1'b0;
        push_n("err_high", 5, 1'b1, 1'b0, S_RUN);
        push_n("err_low", 6, 1'b0, 1'b0, S_RUN);
        push_period("err_p12", 6);
        drain();

        // 5: reset during the high phase clears outputs immediately
        push("pre_rst_rise", 1'b1, 1'b1, S_RUN);
        drain();
        reset = 1'b0;
        #1;
        push("async_rst", 1'b0, 1'b0, S_HALT);
        check_now();
        mode = 2'b00; div_load = 1'b1; div_value = 20'd9;
        push_n("rst_hold", 2, 1'b0, 1'b0, S_HALT);
        drain();
        div_load = 1'b0;
        push("rst_hold", 1'b0, 1'b0, S_HALT);
        drain();
        reset = 1'b1;
        push("rst_release", 1'b0, 1'b0, S_HALT);
        drain();
        mode = 2'b01;
        push_n("rst_run", 4, 1'b0, 1'b0, S_RUN);
        push_period("rst_p8", 4);
        push("rst_rise", 1'b1, 1'b1, S_RUN);
        push_n("rst_high", 3, 1'b1, 1'b0, S_RUN);
        push("rst_fall", 1'b0, 1'b0, S_RUN);
        drain();
        mode = 2'b00;
        push("exit_now", 1'b0, 1'b0, S_HALT);
        drain();

        // Loads outside RUN: zero rejected, 5 applied at once
        div_load = 1'b1; div_value = 20'd0;
        push("halt_err0", 1'b0, 1'b0, S_HALT, 1'b0, 1'b1);
        drain();
        div_value = 20'd5;
        push("halt_ack5", 1'b0, 1'b0, S_HALT, 1'b1, 1'b0);
        drain();
        div_load = 1'b0;
        mode = 2'b01;
        push_n("run5_low", 5, 1'b0, 1'b0, S_RUN);
        push("run5_rise", 1'b1, 1'b1, S_RUN);
        drain();

        // Two loads before one wrap: second value wins, single ack
        div_load = 1'b1; div_value = 20'd3;
        push("ovr_first", 1'b1, 1'b0, S_RUN);
        drain();
        div_value = 20'd7;
        push("ovr_second", 1'b1, 1'b0, S_RUN);
        drain();
        div_load = 1'b0;
        push_n("ovr_high", 2, 1'b1, 1'b0, S_RUN);
        push("ovr_ack", 1'b0, 1'b0, S_RUN, 1'b1, 1'b0);
        push_n("ovr_low7", 6, 1'b0, 1'b0, S_RUN);
        push_period("ovr_p14", 7);
        drain();

        // Mode 11 late in the low phase: full high phase, then HALT
        mode = 2'b11;
        push("m11_rise", 1'b1, 1'b1, S_RUN);
        push_n("m11_high", 6, 1'b1, 1'b0, S_RUN);
        push("m11_fall", 1'b0, 1'b0, S_HALT);
        push_n("m11_hold", 2, 1'b0, 1'b0, S_HALT);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
